// File: rtl/generador_sincronia_if.sv
// generador_sincronia_if: VGA timing bundle (counters, syncs, visible flag, pixel tick, frame pulse).
// The master drives it, the slave observes it.
interface generador_sincronia_if;
    logic [9:0] Qh;
    logic [9:0] Qv;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_start;
    modport master (output Qh, Qv, hsync, vsync, video_on, p_tick, frame_start);
    modport slave  (input  Qh, Qv, hsync, vsync, video_on, p_tick, frame_start);
endinterface

// File: rtl/generador_sincronia.sv
// generador_sincronia: 640x480 VGA timing generator with registered counters and sync outputs.
// PIXEL_DIV_EN: 100 MHz reloj divided by 4 to the pixel rate; otherwise reloj is the pixel clock.
module generador_sincronia (
    input  logic                          reloj,
    input  logic                          resetM,
    generador_sincronia_if.master         vga
);
    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_MAX  = 10'd799;
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_MAX  = 10'd524;
    localparam logic [9:0] H_SS   = H_VIS + H_FP;
    localparam logic [9:0] H_SE   = H_SS + H_SYNC - 10'd1;
    localparam logic [9:0] V_SS   = V_VIS + V_FP;
    localparam logic [9:0] V_SE   = V_SS + V_SYNC - 10'd1;

    logic       tick_q;
    logic       tick_d;
    logic [9:0] qh_q, qh_d;
    logic [9:0] qv_q, qv_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       frame_start_q, frame_start_d;

`ifdef PIXEL_DIV_EN
    logic [1:0] div_q, div_d;
    always_comb begin
        div_d  = div_q + 2'd1;
        tick_d = div_d == 2'd3;
    end
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) div_q <= 2'd0;
        else        div_q <= div_d;
    end
    assign tick_q = div_q == 2'd3;
`else
    // Degenerate divider: a run flag that rises on the first edge out of reset.
    logic run_q, run_d;
    always_comb begin
        run_d  = 1'b1;
        tick_d = 1'b1;
    end
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) run_q <= 1'b0;
        else        run_q <= run_d;
    end
    assign tick_q = run_q;
`endif

    // Syncs and flags are decoded from the next counter values so they line up with Qh/Qv.
    always_comb begin
        qh_d = qh_q;
        qv_d = qv_q;
        if (tick_q) begin
            qh_d = (qh_q >= H_MAX) ? 10'd0 : qh_q + 10'd1;
            qv_d = (qv_q > V_MAX) ? 10'd0 :
                   (qh_q == H_MAX) ? ((qv_q == V_MAX) ? 10'd0 : qv_q + 10'd1) : qv_q;
        end
        hsync_d       = !(qh_d >= H_SS && qh_d <= H_SE);
        vsync_d       = !(qv_d >= V_SS && qv_d <= V_SE);
        video_on_d    = (qh_d < H_VIS) && (qv_d < V_VIS);
        frame_start_d = tick_d && (qh_d == 10'd0) && (qv_d == 10'd0);
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            qh_q          <= 10'd0;
            qv_q          <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            qh_q          <= qh_d;
            qv_q          <= qv_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.Qh          = qh_q;
    assign vga.Qv          = qv_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.frame_start = frame_start_q;
    assign vga.p_tick      = tick_q;
endmodule

// File: doc/generador_sincronia.md
GENERADOR_SINCRONIA -- requirements
Module: generador_sincronia

Interface
REQ-001 The block SHALL have port `reloj`: input, 1 bit, system clock; all state changes on its rising edge.
REQ-002 The block SHALL have port `resetM`: input, 1 bit, asynchronous active-high reset.
REQ-003 The block SHALL have port `Qh`: output, 10 bits, horizontal pixel counter, 0..799.
REQ-004 The block SHALL have port `Qv`: output, 10 bits, vertical line counter, 0..524.
REQ-005 The block SHALL have port `hsync`: output, 1 bit, horizontal sync, active low.
REQ-006 The block SHALL have port `vsync`: output, 1 bit, vertical sync, active low.
REQ-007 The block SHALL have port `video_on`: output, 1 bit, high inside the 640x480 visible area.
REQ-008 The block SHALL have port `p_tick`: output, 1 bit, pixel-rate enable, one `reloj` cycle wide.
REQ-009 The block SHALL have port `frame_start`: output, 1 bit, one-cycle pulse marking the start of each frame.

Function
REQ-010 The block SHALL generate VGA 640x480 timing:
  - H: 640 visible, 16 front porch, 96 sync, 48 back porch; total 800.
  - V: 480 visible, 10 front porch, 2 sync, 33 back porch; total 525.
REQ-011 `Qh` and `Qv` SHALL be registered and SHALL change only on a `reloj` edge where `p_tick`=1.
REQ-012 On a tick, `Qh` SHALL increment; at `Qh`=799 it SHALL wrap to 0.
REQ-013 `Qv` SHALL increment only on a tick where `Qh`=799; at `Qv`=524 under that condition it SHALL wrap to 0, so `Qh` and `Qv` wrap on the same edge.
REQ-014 `hsync`, `vsync` and `video_on` SHALL be registered, computed each clock from the next-state counter values, so that they are coherent with the `Qh`/`Qv` presented in the same cycle.
REQ-015 `hsync` SHALL be 0 iff 656 <= `Qh` <= 751, else 1.
REQ-016 `vsync` SHALL be 0 iff 490 <= `Qv` <= 491, else 1.
REQ-017 `video_on` SHALL be 1 iff `Qh` < 640 and `Qv` < 480.
REQ-018 `frame_start` SHALL be 1 for exactly the one cycle in which `Qh`=0, `Qv`=0 and `p_tick`=1.
REQ-019 `frame_start` SHALL also pulse on the first tick after reset.
REQ-020 Counters SHALL NOT take values outside their ranges; any out-of-range value SHALL load 0 on the next tick.
REQ-021 `Qh`/`Qv` to sync latency SHALL be 0 cycles; all outputs SHALL be glitch-free registered signals, except `p_tick`, which SHALL be a decode of a registered divider.

Reset
REQ-022 While `resetM`=1, the outputs SHALL be: `Qh`=0, `Qv`=0, `hsync`=1, `vsync`=1, `video_on`=0, `frame_start`=0, `p_tick`=0.
REQ-023 The internal divider SHALL clear to 0 on reset.
REQ-024 Reset assertion mid-line or mid-frame SHALL take effect immediately, with no clock required.
REQ-025 On the first `reloj` edge after reset deassertion, `video_on` SHALL go to 1, with the counters still at 0.
REQ-026 Counting SHALL resume from 0,0 after reset.

Configuration
REQ-027 The block SHALL support macro `PIXEL_DIV_EN`.
  - Defined: `reloj` is 100 MHz. A 2-bit divider counts 0..3 continuously; `p_tick`=1 when the divider is 3. Pixel rate is `reloj`/4. The first tick occurs 3 edges after reset release.
  - Undefined: `reloj` is 25 MHz. There is no divider; `p_tick`=1 in every cycle out of reset, and 0 during reset.
REQ-028 Apart from `p_tick` cadence, behaviour SHALL be identical with and without `PIXEL_DIV_EN`.

Verification
REQ-029 Reset release, with `PIXEL_DIV_EN` -> `p_tick` first high on cycle 3; `Qh`=1 after edge 4; `Qh` steps every 4 cycles thereafter.
REQ-030 Run one full line -> `Qh` goes 799->0 and `Qv` 0->1 on the same edge; `hsync` low for exactly 96 ticks, starting when `Qh`=656.
REQ-031 Run one full frame -> 525 lines of 800 ticks each (420000 ticks); `vsync` low only at `Qv`=490,491; `frame_start` pulses exactly once per 420000 ticks.
REQ-032 Sample `video_on` -> 1 at (639,479); 0 at (640,0), at (0,480) and at (799,524).
REQ-033 Assert `resetM` asynchronously at `Qh`=700, `Qv`=300 -> all outputs reach their reset values before the next edge; after release, counting restarts at 0,0.
REQ-034 Without `PIXEL_DIV_EN` -> `p_tick` constantly 1; the line period is 800 `reloj` cycles and the frame period is 420000 cycles.
